uart_tx_cfg: RTL

Parametrised UART serialiser that replaces the fixed 8N1, 9600-baud transmitter. Data width, parity mode, stop-bit count and baud divisor are set at elaboration. A valid/ready handshake with a one-entry holding register allows back-to-back frames with no idle gap. It sits between any byte producer (message sequencer, FIFO) and the board `tx` pin.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_cfg_if.sv | 15 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_cfg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the configurable UART transmitter and the
// future receiver.
//   PARITY_*      parity mode encodings used by the PARITY parameter
//   uart_state_e  frame state encoding
//   parity_bit()  parity bit for a payload, zero-extended to MAX_DATA_BITS
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the payload (total ones becomes even); odd
  // parity is its complement. Zero-extension does not change the result.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready byte handshake into the UART transmitter.
//   tx_data   payload word, sampled only on tx_valid && tx_ready
//   tx_valid  producer has a word
//   tx_ready  transmitter holding register is empty
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer, shared by the UART transmitter and receiver.
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       restart the period (counter to 0 on the next edge)
//   tick        high in the last cycle of each CPB-cycle period
module uart_baud_tick #(
  parameter int CPB = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CPB);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CPB - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values regardless of process ordering.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART serialiser with a one-entry holding register.
// Frame: start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         valid/ready payload handshake (slave side)
//   tx          registered serial line, idle high
//   busy        a frame is on the line
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CPB       = 1250,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_cfg_if.slave bus,
  output logic         tx,
  output logic         busy
);
  localparam int IDX_W = 4;  // covers both DATA_BITS-1 (max 8) and STOP_BITS-1

  if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      !(PARITY inside {PARITY_NONE, PARITY_ODD, PARITY_EVEN}) ||
      !(STOP_BITS inside {1, 2})) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d;

  logic                 hs;
  logic                 tick;
  logic                 bit_clear;
  logic                 load;
  logic [DATA_BITS-1:0] load_word;

  assign bus.tx_ready = !hold_full_q;
  assign hs           = bus.tx_valid && !hold_full_q;
  assign busy         = (state_q != ST_IDLE);
  assign tx           = tx_q;

  // Every state starts a fresh bit period; within DATA and STOP the timer
  // simply wraps at terminal count.
  assign bit_clear = (state_d != state_q) || (state_q == ST_IDLE);

  uart_baud_tick #(.CPB(CPB)) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bit_clear),
    .tick  (tick)
  );

  always_comb begin
    // NOTE: every _d signal and local takes a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    par_d       = par_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    load        = 1'b0;
    load_word   = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // A word parked while the last frame ended still gets one idle cycle.
        if (hold_full_q) begin
          load = 1'b1;
        end else if (hs) begin
          load      = 1'b1;
          load_word = bus.tx_data;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (hold_full_q) begin
              load = 1'b1;  // back-to-back: next start bit with no idle gap
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d     = ST_START;
      shift_d     = load_word;
      par_d       = parity_bit(MAX_DATA_BITS'(load_word), PARITY);
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
    end

    // tx_ready is low whenever the holding register is full, so this never
    // coincides with a load from the holding register.
    if (hs && state_q != ST_IDLE) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well as the control flops; it is
      // only a handful of bits and keeps the payload path free of X after reset.
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end
endmodule
